// File: rtl/uart_rx_pkt_ctrl_if.sv
// Payload stream from the packet controller to its consumer.
// The master drives data/valid/last/len and samples ready.
interface uart_rx_pkt_ctrl_if;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_last;
  logic       pkt_ready;
  logic [7:0] pkt_len;

  modport master (
    output pkt_data,
    output pkt_valid,
    output pkt_last,
    output pkt_len,
    input  pkt_ready
  );

  modport slave (
    input  pkt_data,
    input  pkt_valid,
    input  pkt_last,
    input  pkt_len,
    output pkt_ready
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART receiver: frames SOF/LEN/data/CSUM,
// checks length, checksum and inter-byte timeout, streams good payloads.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SOF_BYTE    = 8'h7E,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 312500
) (
  input  logic               clk,
  input  logic               rx_rst,
  input  logic               ctrl_en,
  output logic               rx_en,
  output logic               rx_clr,
  input  logic               rx_done,
  input  logic               rx_err,
  input  logic [7:0]         rx_data,
  uart_rx_pkt_ctrl_if.master pkt,
  output logic               pkt_ok,
  output logic               pkt_err,
  output logic [1:0]         err_code,
  output logic               drop
);

  localparam int IW    = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [7:0]    MAXL    = 8'(MAX_LEN);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] E_FRAME = 2'd0;
  localparam logic [1:0] E_LEN   = 2'd1;
  localparam logic [1:0] E_CSUM  = 2'd2;
  localparam logic [1:0] E_TMO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DELIVER,
    S_FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          drop_q, drop_d;
  logic [1:0]    code_q, code_d;
  logic          en_q;
  logic          wr_en;
  logic [7:0]    buf_q [DEPTH];

  logic [7:0] len_m1;
  logic       wr_last;
  logic       rd_last;
  logic       in_dlv;

  assign len_m1  = len_q - 8'd1;
  assign wr_last = (8'(idx_q) == len_m1);
  assign rd_last = (8'(rd_q) == len_m1);
  assign in_dlv  = (state_q == S_DELIVER);

  assign rx_en         = en_q;
  assign rx_clr        = (state_q == S_FLUSH);
  assign pkt.pkt_valid = in_dlv;
  assign pkt.pkt_data  = in_dlv ? buf_q[rd_q[AW-1:0]] : 8'h00;
  assign pkt.pkt_last  = in_dlv && rd_last;
  assign pkt.pkt_len   = len_q;
  assign pkt_ok        = ok_q;
  assign pkt_err       = err_q;
  assign err_code      = code_q;
  assign drop          = drop_q;

  // Next-state, status pulses and datapath updates for the framing FSM.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    cnt_d   = '0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    code_d  = code_q;
    wr_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_err) begin
          err_d   = 1'b1;
          code_d  = E_FRAME;
          state_d = S_FLUSH;
        end else if (rx_done && ctrl_en && rx_data == SOF_BYTE) begin
          state_d = S_LEN;
        end
      end

      S_LEN, S_PAYLOAD, S_CSUM: begin
        if (!(rx_done || rx_err)) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (rx_err) begin
          err_d   = 1'b1;
          code_d  = E_FRAME;
          state_d = S_FLUSH;
        end else if (rx_done) begin
          if (state_q == S_LEN) begin
            len_d  = rx_data;
            csum_d = rx_data;
            idx_d  = '0;
            if (rx_data == 8'd0 || rx_data > MAXL) begin
              err_d   = 1'b1;
              code_d  = E_LEN;
              state_d = S_IDLE;
            end else begin
              state_d = S_PAYLOAD;
            end
          end else if (state_q == S_PAYLOAD) begin
            wr_en  = 1'b1;
            csum_d = csum_q ^ rx_data;
            idx_d  = idx_q + IW'(1);
            if (wr_last) begin
              state_d = S_CSUM;
            end
          end else begin
            if (rx_data == csum_q) begin
              ok_d    = 1'b1;
              rd_d    = '0;
              state_d = S_DELIVER;
            end else begin
              err_d   = 1'b1;
              code_d  = E_CSUM;
              state_d = S_IDLE;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          code_d  = E_TMO;
          state_d = S_IDLE;
        end
      end

      S_DELIVER: begin
        drop_d = rx_done || rx_err;
        if (pkt.pkt_ready) begin
          rd_d = rd_q + IW'(1);
          if (rd_last) begin
            state_d = S_IDLE;
          end
        end
      end

      S_FLUSH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      len_q  <= '0;
      csum_q <= '0;
      idx_q  <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      code_q <= '0;
      en_q   <= 1'b0;
    end else begin
      len_q  <= len_d;
      csum_q <= csum_d;
      idx_q  <= idx_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      drop_q <= drop_d;
      code_q <= code_d;
      en_q   <= ctrl_en;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[idx_q[AW-1:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl.
// Expected payload bytes are queued as packets are sent.
module tb_uart_rx_pkt_ctrl;
  localparam int         TMO = 50;
  localparam logic [7:0] SOF = 8'h7E;

  logic       clk = 1'b0;
  logic       rx_rst, ctrl_en, rx_done, rx_err;
  logic [7:0] rx_data;
  logic       rx_en, rx_clr, pkt_ok, pkt_err, drop;
  logic [1:0] err_code;

  uart_rx_pkt_ctrl_if pif ();

  uart_rx_pkt_ctrl #(
    .SOF_BYTE(SOF),
    .MAX_LEN(16),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rx_rst(rx_rst),
    .ctrl_en(ctrl_en),
    .rx_en(rx_en),
    .rx_clr(rx_clr),
    .rx_done(rx_done),
    .rx_err(rx_err),
    .rx_data(rx_data),
    .pkt(pif),
    .pkt_ok(pkt_ok),
    .pkt_err(pkt_err),
    .err_code(err_code),
    .drop(drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int ok_cnt, err_cnt, drop_cnt, clr_cnt, valid_cnt, stall_cnt;
  logic [16:0] exp_q [$];
  logic [7:0]  pay [256];
  logic        stalled = 1'b0;
  logic [7:0]  hold_d;

  // Monitor: pulse counters, hold check and scoreboard pop.
  always @(negedge clk) begin
    logic [16:0] e;
    if (pkt_ok) ok_cnt++;
    if (pkt_err) err_cnt++;
    if (drop) drop_cnt++;
    if (rx_clr) clr_cnt++;
    if (pif.pkt_valid) valid_cnt++;
    if (pif.pkt_valid) begin
      if (stalled) begin
        n_chk++;
        if (pif.pkt_data !== hold_d)
          $display("FAIL hold: data %02h required %02h", pif.pkt_data, hold_d);
        else n_pass++;
      end
      if (pif.pkt_ready) begin
        stalled = 1'b0;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: data %02h required none", pif.pkt_data);
        end else begin
          e = exp_q.pop_front();
          if ({pif.pkt_last, pif.pkt_data, pif.pkt_len} !== e)
            $display("FAIL beat: last/data/len %0b/%02h/%0d required %0b/%02h/%0d",
                     pif.pkt_last, pif.pkt_data, pif.pkt_len, e[16], e[15:8], e[7:0]);
          else n_pass++;
        end
      end else begin
        stalled = 1'b1;
        hold_d  = pif.pkt_data;
        stall_cnt++;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_cnts();
    ok_cnt = 0; err_cnt = 0; drop_cnt = 0;
    clr_cnt = 0; valid_cnt = 0; stall_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_good(input int n);
    logic [7:0] cs;
    cs = 8'(n);
    send_byte(SOF);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), pay[i], 8'(n)});
      cs = cs ^ pay[i];
      send_byte(pay[i]);
    end
    send_byte(cs);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || pif.pkt_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d bytes left required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic chk_status(input string nm, input int ok_x, input int err_x,
                            input logic [1:0] code_x, input int clr_x);
    n_chk++;
    if (ok_cnt != ok_x || err_cnt != err_x || clr_cnt != clr_x ||
        (err_x != 0 && err_code !== code_x))
      $display("FAIL %s: ok/err/code/clr %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
               nm, ok_cnt, err_cnt, err_code, clr_cnt, ok_x, err_x, code_x, clr_x);
    else n_pass++;
  endtask

  task automatic chk_zero(input string nm);
    logic [24:0] z;
    z = {rx_en, rx_clr, pif.pkt_valid, pif.pkt_last, pif.pkt_data,
         pif.pkt_len, pkt_ok, pkt_err, err_code, drop};
    n_chk++;
    if (z !== '0) $display("FAIL %s: outputs %07h required 0", nm, z);
    else n_pass++;
  endtask

  task automatic test_reset();
    rx_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    rx_rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (rx_en !== 1'b1) $display("FAIL rx_en_after_reset: %b required 1", rx_en);
    else n_pass++;
  endtask

  task automatic test_good();
    clr_cnts();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_good(3);
    wait_drain();
    chk_status("good_status", 1, 0, 2'd0, 0);
    n_chk++;
    if (valid_cnt != 3) $display("FAIL good_valid_cycles: %0d required 3", valid_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    clr_cnts();
    pif.pkt_ready = 1'b0;
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    send_good(3);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      pif.pkt_ready = ~pif.pkt_ready;
      rx_done = (i == 0);
      rx_data = 8'h55;
    end
    pif.pkt_ready = 1'b1;
    wait_drain();
    chk_status("bp_status", 1, 0, 2'd0, 0);
    n_chk++;
    if (drop_cnt != 1 || stall_cnt == 0)
      $display("FAIL bp_drop: drop/stall %0d/%0d required 1/>0", drop_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_errors();
    clr_cnts();
    send_byte(SOF); send_byte(8'h02); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'h00);
    wait_drain();
    chk_status("csum_err", 0, 1, 2'd2, 0);
    n_chk++;
    if (valid_cnt != 0) $display("FAIL csum_valid: %0d required 0", valid_cnt);
    else n_pass++;
    clr_cnts();
    send_byte(SOF); send_byte(8'h00);
    wait_drain();
    chk_status("len0_err", 0, 1, 2'd1, 0);
    clr_cnts();
    send_byte(SOF); send_byte(8'h11);
    wait_drain();
    chk_status("len17_err", 0, 1, 2'd1, 0);
  endtask

  task automatic test_frame();
    clr_cnts();
    send_byte(SOF); send_byte(8'h02);
    @(posedge clk); #1;
    rx_err = 1'b1;
    @(posedge clk); #1;
    rx_err = 1'b0;
    wait_drain();
    chk_status("frame_err", 0, 1, 2'd0, 1);
    clr_cnts();
    pay[0] = 8'h5A;
    send_good(1);
    wait_drain();
    chk_status("frame_recover", 1, 0, 2'd0, 0);
  endtask

  task automatic test_timeout();
    int k = -1;
    clr_cnts();
    send_byte(SOF); send_byte(8'h02); send_byte(8'hAA);
    for (int i = 1; i <= 200 && k < 0; i++) begin
      @(posedge clk); #1;
      if (pkt_err) k = i;
    end
    n_chk++;
    if (k != TMO) $display("FAIL timeout_latency: %0d required %0d", k, TMO);
    else n_pass++;
    wait_drain();
    chk_status("timeout_err", 0, 1, 2'd3, 0);
  endtask

  task automatic test_reset_mid();
    clr_cnts();
    send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
    rx_rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("reset_mid");
    rx_rst = 1'b0;
    clr_cnts();
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04;
    send_good(3);
    wait_drain();
    chk_status("reset_recover", 1, 0, 2'd0, 0);
  endtask

  task automatic test_simultaneous();
    clr_cnts();
    send_byte(SOF);
    @(posedge clk); #1;
    rx_done = 1'b1; rx_err = 1'b1; rx_data = 8'h03;
    @(posedge clk); #1;
    rx_done = 1'b0; rx_err = 1'b0;
    wait_drain();
    chk_status("simul_err", 0, 1, 2'd0, 1);
    clr_cnts();
    pay[0] = 8'h99; pay[1] = 8'h66;
    send_good(2);
    wait_drain();
    chk_status("simul_recover", 1, 0, 2'd0, 0);
  endtask

  task automatic test_enable();
    clr_cnts();
    send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
    ctrl_en = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (rx_en !== 1'b0) $display("FAIL rx_en_fall: %b required 0", rx_en);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    ctrl_en = 1'b1;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    wait_drain();
    chk_status("enable_abort", 0, 0, 2'd0, 0);
    n_chk++;
    if (valid_cnt != 0) $display("FAIL enable_valid: %0d required 0", valid_cnt);
    else n_pass++;
  endtask

  task automatic test_max_len();
    clr_cnts();
    for (int i = 0; i < 16; i++) pay[i] = 8'(i * 13 + 5);
    send_good(16);
    wait_drain();
    chk_status("max_len", 1, 0, 2'd0, 0);
  endtask

  task automatic test_back_to_back();
    clr_cnts();
    pay[0] = 8'hA5;
    send_good(1);
    pay[0] = 8'h3C;
    send_good(1);
    wait_drain();
    chk_status("b2b", 2, 0, 2'd0, 0);
    n_chk++;
    if (drop_cnt != 0) $display("FAIL b2b_drop: %0d required 0", drop_cnt);
    else n_pass++;
  endtask

  initial begin
    rx_rst = 1'b1; ctrl_en = 1'b1;
    rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    pif.pkt_ready = 1'b1;
    clr_cnts();
    test_reset();
    test_good();
    test_backpressure();
    test_errors();
    test_frame();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    test_enable();
    test_max_len();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Sequencing controller placed after the UART receiver (rx_top_module). It enables the receiver and recovers it after frame errors. It assembles received bytes into framed packets of the form SOF, LEN, payload, CSUM, checks the length and checksum, and enforces an inter-byte timeout. Validated payloads are streamed to the downstream consumer over a valid/ready interface, and the outcome of every packet is reported as a status pulse.

Parameters:
SOF_BYTE, 8'h7E, start-of-frame marker.
MAX_LEN, 16, maximum payload length in bytes; legal range 1..255. Sets the depth of the internal buffer.
TIMEOUT_CYC, 312500, idle cycles allowed between bytes inside a packet. This is about 3 byte times at 100 MHz / 9600 baud.

Ports:
clk  in  1  system clock, 100 MHz nominal.
rx_rst  in  1  synchronous, active-high reset.
ctrl_en  in  1  controller enable.
rx_en  out  1  enable to the receiver.
rx_clr  out  1  one-cycle synchronous clear pulse to the receiver's rx_rst.
rx_done  in  1  receiver byte-complete pulse; rx_data is valid in the same cycle.
rx_err  in  1  receiver frame-error pulse (bad stop bit).
rx_data  in  8  received byte.
pkt_data  out  8  payload byte.
pkt_valid  out  1  payload byte valid.
pkt_last  out  1  final payload byte of the packet.
pkt_ready  in  1  downstream accept.
pkt_len  out  8  LEN of the packet being delivered; held during DELIVER.
pkt_ok  out  1  one-cycle pulse: packet validated.
pkt_err  out  1  one-cycle pulse: packet rejected.
err_code  out  2  cause of the last pkt_err: 0 frame, 1 length, 2 checksum, 3 timeout. Held until the next pkt_err.
drop  out  1  one-cycle pulse: a byte arrived during DELIVER and was discarded.

Behaviour:
- Reset (rx_rst=1 at a clk edge): state IDLE. Every output is 0, including rx_en, rx_clr, err_code and pkt_len. Buffer contents are don't-care. Reset mid-packet or mid-delivery aborts immediately with no status pulse.
- rx_en is a register: rx_en <= ctrl_en, one cycle of latency.
- States: IDLE, LEN, PAYLOAD, CSUM, DELIVER, FLUSH.
- IDLE: on rx_done with rx_data==SOF_BYTE, go to LEN. Other bytes are ignored silently.
- LEN: on rx_done, latch LEN and seed csum_acc=LEN.
  - If LEN==0 or LEN>MAX_LEN: pkt_err with code 1, go to IDLE.
  - Otherwise go to PAYLOAD with idx=0.
- PAYLOAD: each rx_done writes buf[idx], does csum_acc ^= rx_data, and increments idx. When idx reaches LEN-1 on a write, go to CSUM.
- CSUM: on rx_done, compare rx_data against csum_acc.
  - Equal: go to DELIVER; pkt_ok pulses on the cycle after the CSUM byte.
  - Not equal: pkt_err with code 2, go to IDLE.
- Frame error: rx_err in any state except DELIVER gives pkt_err code 0 and a transition to FLUSH.
  - FLUSH asserts rx_clr for exactly one cycle, then returns to IDLE.
  - In IDLE the same rule applies: pkt_err code 0 is still reported.
  - In DELIVER, rx_err is treated like a dropped byte: drop pulses and there is no FLUSH.
- Simultaneous rx_done and rx_err: rx_err wins and the byte is discarded.
- Timeout: the counter clears on every rx_done/rx_err and counts only in LEN, PAYLOAD and CSUM. When it reaches TIMEOUT_CYC-1: pkt_err code 3, go to IDLE.
- DELIVER:
  - pkt_valid=1 and pkt_data=buf[rd_idx], starting at rd_idx=0.
  - A transfer occurs on pkt_valid & pkt_ready, which increments rd_idx.
  - pkt_last=1 when rd_idx==LEN-1.
  - After the last transfer, go to IDLE; pkt_valid=0 on the next cycle.
  - pkt_data is stable while pkt_valid=1 and pkt_ready=0.
  - Bytes arriving during DELIVER are discarded and pulse drop.
- Status outputs: pkt_ok and pkt_err are mutually exclusive and each lasts one cycle. err_code updates in the same cycle as pkt_err.
- ctrl_en=0:
  - In LEN, PAYLOAD or CSUM: abort to IDLE with no pulse.
  - In DELIVER: takes effect only after the last transfer.
  - In IDLE: incoming bytes are ignored.
- Widths: idx and rd_idx are clog2(MAX_LEN+1) bits. The timeout counter is clog2(TIMEOUT_CYC) bits. csum_acc is 8-bit XOR.

Test Plan:
- Good packet: drive rx_done bytes 7E 03 11 22 33 03 with pkt_ready=1. Expect pkt_ok once, then pkt_data 11, 22, 33 on consecutive cycles, pkt_last on 33, pkt_len=3, and no pkt_err.
- Backpressure: same packet with pkt_ready toggling 0/1 every cycle. Expect data to hold while stalled and all 3 bytes delivered in order. A byte 55 injected during DELIVER pulses drop, and the delivered data is unchanged.
- Checksum and length errors: 7E 02 AA BB 00 gives pkt_err with err_code=2 and no pkt_valid. 7E 00 gives err_code=1. 7E 11 (17 > MAX_LEN) gives err_code=1.
- Frame error: 7E 02 then rx_err. Expect pkt_err with err_code=0, rx_clr high for exactly 1 cycle, and a following good packet received correctly.
- Timeout: 7E 02 AA, then silence. Expect pkt_err with err_code=3 exactly TIMEOUT_CYC cycles after AA (bench overrides TIMEOUT_CYC=50). Also rx_done and rx_err in the same cycle gives a code-0 error.
- Reset and enable: assert rx_rst mid-PAYLOAD and check that all outputs are 0 and the next packet is clean. Drop ctrl_en mid-PAYLOAD and check that rx_en falls after 1 cycle with no status pulse.
